stack_engine: RTL
=================

// Module: stack_engine
// PURPOSE
//  Memory-side executor for the RNBIP-2 stack: accepts push/pop/load-SP ops from the
//  control unit over a valid/ready handshake and performs the data-RAM write or read.
//  Owns the stack pointer (SP = next free slot, grows downward from STACK_TOP).
//  Returns the pop data and an error flag over a valid/ready response channel.
//  Sits between the control unit and the single-port data RAM.
// PARAMETERS
//  DATA_W       8      data width
//  ADDR_W       8      RAM address width
//  STACK_TOP    8'hFF  SP reset value; highest stack slot
//  STACK_BOTTOM 8'hAF  lowest stack slot; capacity = STACK_TOP-STACK_BOTTOM+1 = 81
//  RD_LAT       1      RAM read latency in cycles (>=1)
// PORTS
//  clk        in   1       clock, all state changes on posedge
//  rst_n      in   1       asynchronous active-low reset
//  op_valid   in   1       op request valid
//  op_ready   out  1       engine idle, op accepted when op_valid&op_ready
//  op_code    in   2       00 nop, 01 push, 10 pop, 11 load SP
//  op_wdata   in   DATA_W  push data / new SP value for load
//  rsp_valid  out  1       response valid; held until rsp_ready
//  rsp_ready  in   1       response consumed
//  rsp_rdata  out  DATA_W  pop data (0 for other ops and on error)
//  rsp_err    out  1       op rejected (overflow/underflow/bad load)
//  mem_addr   out  ADDR_W  RAM address
//  mem_we     out  1       RAM write strobe
//  mem_re     out  1       RAM read strobe
//  mem_wdata  out  DATA_W  RAM write data
//  mem_rdata  in   DATA_W  RAM read data, valid RD_LAT cycles after mem_re
//  sp         out  ADDR_W  current SP
//  full       out  1       SP == STACK_BOTTOM-1
//  empty      out  1       SP == STACK_TOP
// BEHAVIOUR
//  Reset (async, any state): state IDLE, SP=STACK_TOP, op_ready=1, rsp_valid=0,
//   rsp_rdata=0, rsp_err=0, mem_we=mem_re=0, mem_addr=0, mem_wdata=0; in-flight op dropped.
//  All outputs registered or decoded from state only; no input->output comb path.
//  FSM: IDLE, WRITE, READ, WAIT, RESP. op_ready=1 only in IDLE. op_code/op_wdata latched on accept.
//  Accept at cycle T:
//   push, !full : WRITE at T+1 (mem_we=1, mem_addr=SP, mem_wdata=data); SP<=SP-1 at end of T+1;
//                 RESP from T+2, err=0.
//   push, full  : no RAM access, SP unchanged; RESP from T+1, err=1.
//   pop, !empty : READ at T+1 (mem_re=1, mem_addr=SP+1); WAIT RD_LAT cycles; mem_rdata captured
//                 in last WAIT cycle, SP<=SP+1 same edge; RESP from T+2+RD_LAT, rdata=captured.
//   pop, empty  : no RAM access; RESP from T+1, err=1, rdata=0.
//   load        : op_wdata in [STACK_BOTTOM-1, STACK_TOP] -> SP<=op_wdata at end of T, err=0;
//                 else SP unchanged, err=1. RESP from T+1.
//   nop         : RESP from T+1, err=0.
//  RESP: rsp_valid=1, rsp_rdata/rsp_err stable until rsp_ready sampled high; then IDLE next
//   cycle (op_ready=1 then). Back-to-back ops: one accept per RESP->IDLE round trip.
//  mem_we/mem_re each exactly one cycle per successful op, never both high.
//  SP arithmetic modulo 2^ADDR_W but never leaves [STACK_BOTTOM-1, STACK_TOP] except via
//   reset; full/empty update the cycle after SP changes.
//  op_valid while busy is ignored (not accepted, no side effects).
// TESTING
//  Reset -> sp=FF, empty=1, full=0, op_ready=1, rsp_valid=0, mem_we=mem_re=0.
//  push 8'h5A from reset -> mem_we at T+1, addr FF, wdata 5A; rsp_valid T+2 err=0; sp=FE.
//  push 5A, push 3C, pop, pop (RAM model RD_LAT=1) -> rdata 3C then 5A, addr FE then FF; sp=FF.
//  81 pushes -> full=1, sp=AE; 82nd push -> err=1, no mem_we; pop on empty -> err=1, rdata=0.
//  load 8'hC0 -> sp=C0 err=0; load 8'h10 -> err=1, sp stays C0; rsp_ready low 5 cycles -> rsp held.
//  rst_n low during WAIT of a pop -> immediate mem_re=0, rsp_valid=0, sp=FF; no response issued.

Source files
------------

// File: rtl/stack_engine_if.sv
// Op/response handshake and data-RAM port shared by the control unit and the stack engine.
interface stack_engine_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
);
   logic              op_valid;
   logic              op_ready;
   logic [1:0]        op_code;
   logic [DATA_W-1:0] op_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic              mem_re;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport master (
      output op_valid, op_code, op_wdata, rsp_ready, mem_rdata,
      input  op_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_we, mem_re, mem_wdata
   );

   modport slave (
      input  op_valid, op_code, op_wdata, rsp_ready, mem_rdata,
      output op_ready, rsp_valid, rsp_rdata, rsp_err, mem_addr, mem_we, mem_re, mem_wdata
   );
endinterface

// File: rtl/stack_engine.sv
// Stack executor: turns push/pop/load-SP ops into single RAM accesses and owns the
// downward-growing stack pointer (SP = next free slot).
module stack_engine #(
   parameter int                DATA_W       = 8,
   parameter int                ADDR_W       = 8,
   parameter logic [ADDR_W-1:0] STACK_TOP    = 8'hFF,
   parameter logic [ADDR_W-1:0] STACK_BOTTOM = 8'hAF,
   parameter int                RD_LAT       = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   stack_engine_if.slave     bus,
   output logic [ADDR_W-1:0] sp,
   output logic              full,
   output logic              empty
);
   typedef enum logic [2:0] {IDLE, WRITE, READ, WAIT, RESP} state_t;

   localparam logic [ADDR_W-1:0] SP_LOW   = STACK_BOTTOM - 1'b1;
   localparam logic [ADDR_W-1:0] SP_SPAN  = STACK_TOP - SP_LOW;
   localparam int                CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RD_LAT - 1);

   state_t            r_state;
   logic [ADDR_W-1:0] r_sp;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_full;
   logic              r_empty;
   logic [DATA_W-1:0] r_rsp_rdata;
   logic              r_rsp_err;
   logic [ADDR_W-1:0] r_mem_addr;
   logic              r_mem_we;
   logic              r_mem_re;
   logic [DATA_W-1:0] r_mem_wdata;

   logic [ADDR_W-1:0] w_new_sp;
   logic [ADDR_W-1:0] w_new_off;
   logic              w_load_ok;
   logic              w_full_now;
   logic              w_empty_now;

   // Range check done as an offset from the lowest legal SP so it stays valid modulo 2^ADDR_W.
   assign w_new_sp    = ADDR_W'(bus.op_wdata);
   assign w_new_off   = w_new_sp - SP_LOW;
   assign w_load_ok   = (w_new_off <= SP_SPAN);
   assign w_full_now  = (r_sp == SP_LOW);
   assign w_empty_now = (r_sp == STACK_TOP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_sp        <= STACK_TOP;
         r_cnt       <= '0;
         r_full      <= 1'b0;
         r_empty     <= 1'b1;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_we    <= 1'b0;
         r_mem_re    <= 1'b0;
         r_mem_wdata <= '0;
      end else begin
         r_full  <= w_full_now;
         r_empty <= w_empty_now;
         case (r_state)
            IDLE: begin
               if (bus.op_valid) begin
                  case (bus.op_code)
                     2'b01: begin
                        if (w_full_now) begin
                           r_rsp_err <= 1'b1;
                           r_state   <= RESP;
                        end else begin
                           r_mem_we    <= 1'b1;
                           r_mem_addr  <= r_sp;
                           r_mem_wdata <= bus.op_wdata;
                           r_state     <= WRITE;
                        end
                     end
                     2'b10: begin
                        if (w_empty_now) begin
                           r_rsp_err <= 1'b1;
                           r_state   <= RESP;
                        end else begin
                           r_mem_re   <= 1'b1;
                           r_mem_addr <= r_sp + 1'b1;
                           r_state    <= READ;
                        end
                     end
                     2'b11: begin
                        if (w_load_ok) begin
                           r_sp <= w_new_sp;
                        end else begin
                           r_rsp_err <= 1'b1;
                        end
                        r_state <= RESP;
                     end
                     default: r_state <= RESP;
                  endcase
               end
            end
            WRITE: begin
               r_mem_we <= 1'b0;
               r_sp     <= r_sp - 1'b1;
               r_state  <= RESP;
            end
            READ: begin
               r_mem_re <= 1'b0;
               r_cnt    <= '0;
               r_state  <= WAIT;
            end
            // Read data is sampled in the last latency cycle, together with the SP release.
            WAIT: begin
               if (r_cnt == CNT_LAST) begin
                  r_rsp_rdata <= bus.mem_rdata;
                  r_sp        <= r_sp + 1'b1;
                  r_state     <= RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RESP: begin
               if (bus.rsp_ready) begin
                  r_rsp_rdata <= '0;
                  r_rsp_err   <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.op_ready  = (r_state == IDLE);
   assign bus.rsp_valid = (r_state == RESP);
   assign bus.rsp_rdata = r_rsp_rdata;
   assign bus.rsp_err   = r_rsp_err;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_re    = r_mem_re;
   assign bus.mem_wdata = r_mem_wdata;
   assign sp            = r_sp;
   assign full          = r_full;
   assign empty         = r_empty;
endmodule
